// File: rtl/wait_state_mem_pkg.sv
// rtl/wait_state_mem_pkg.sv - shared types, constants and helpers for wait_state_mem
package wait_state_mem_pkg;

    // Controller phases: nothing pending, counting wait states, completion cycle
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Wait-state counter width; covers latencies up to 15
    localparam int CNT_W = 4;

    // Ceiling log2 usable in constant expressions (returns 0 for value <= 1)
    function automatic int clog2_f(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/wait_state_mem_array.sv
// rtl/wait_state_mem_array.sv - single-port byte-enable storage with registered read
module wait_state_mem_array
    import wait_state_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int IW     = 10
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    input  logic                  i_wr_en,
    input  logic                  i_rd_en,
    input  logic [IW-1:0]         i_idx,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [DATA_W/8-1:0]   i_be,
    output logic [DATA_W-1:0]     o_rdata
);

    localparam int BE_W = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Byte-lane write; lanes with a clear enable keep their previous contents
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_be[b]) begin
                    r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read register only loads on a read strobe, so the last result is held
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_rdata <= '0;
        end else if (i_rd_en) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/wait_state_mem.sv
// rtl/wait_state_mem.sv - wait-state memory with ready handshake; optional err output under WAIT_STATE_MEM_ERR_EN
module wait_state_mem
    import wait_state_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 3,
    parameter int WR_LAT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           address,
    input  logic [DATA_W-1:0]     write_data,
    input  logic [DATA_W/8-1:0]   byte_en,
    output logic [DATA_W-1:0]     read_data,
    output logic                  ready,
    output logic                  busy
`ifdef WAIT_STATE_MEM_ERR_EN
    ,
    output logic                  err
`endif
);

    localparam int ALSB = clog2_f(DATA_W / 8);
    localparam int IW   = clog2_f(DEPTH);
    localparam int BE_W = DATA_W / 8;
    localparam logic [CNT_W-1:0] RD_INIT = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_INIT = CNT_W'(WR_LAT - 1);

    state_t             r_state;
    state_t             w_state_nx;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nx;

    logic               r_is_wr;
    logic [IW-1:0]      r_idx;
    logic [DATA_W-1:0]  r_wdata;
    logic [BE_W-1:0]    r_be;

    logic               w_req;
    logic               w_accept;
    logic               w_last;
    logic               w_blocked;
    logic               w_commit;
    logic               w_rd_en;

    assign w_req    = read | write;
    assign w_accept = reset && (r_state != S_BUSY) && w_req;
    assign w_last   = (r_state == S_BUSY) && (r_cnt == '0);
    // Strobes are gated by reset so an abandoned operation never touches the array
    assign w_commit = reset && w_last && r_is_wr && !w_blocked;
    assign w_rd_en  = reset && w_last && !r_is_wr && !w_blocked;

`ifdef WAIT_STATE_MEM_ERR_EN
    localparam logic [31:0] ADDR_MASK = 32'((DEPTH - 1) << ALSB);

    logic w_bad_addr;
    logic r_bad;
    logic r_err;

    // Anything outside the index field (misalignment or aliasing bits) is an error
    assign w_bad_addr = |(address & ~ADDR_MASK);
    assign w_blocked  = r_bad;

    // err rises with ready for a flagged request and lasts only the DONE cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bad <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_bad <= w_bad_addr;
            end
            r_err <= w_last && r_bad;
        end
    end

    assign err = r_err;
`else
    logic w_unused_addr;

    // Out-of-field address bits are deliberately ignored: words alias modulo DEPTH
    assign w_unused_addr = ^address;
    assign w_blocked     = 1'b0;
`endif

    // State and wait-state counter register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Next state: accept in IDLE/DONE, count down in BUSY, complete for one cycle
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_req) begin
                    w_state_nx = S_BUSY;
                    w_cnt_nx   = write ? WR_INIT : RD_INIT;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_BUSY: begin
                if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - 1'b1;
                end else begin
                    w_state_nx = S_DONE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // Request latch; a simultaneous read and write is taken as a write
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_is_wr <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_accept) begin
            r_is_wr <= write;
            r_idx   <= address[ALSB +: IW];
            r_wdata <= write_data;
            r_be    <= byte_en;
        end
    end

    wait_state_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IW     (IW)
    ) u_array (
        .i_clk    (clk),
        .i_resetn (reset),
        .i_wr_en  (w_commit),
        .i_rd_en  (w_rd_en),
        .i_idx    (r_idx),
        .i_wdata  (r_wdata),
        .i_be     (r_be),
        .o_rdata  (read_data)
    );

    assign ready = (r_state == S_DONE);
    assign busy  = (r_state == S_BUSY);

endmodule
